alu_arbiter_2req: RTL and testbench

Shares one alu_32bit instance between two requesters, for example the main pipeline and a multi-cycle helper unit. Each requester presents an operation on a valid/ready request channel. The block arbitrates round-robin, drives the ALU from registered operands, captures the result and zero flag, and returns them on that requester's valid/ready response channel. It also keeps a free-running count of completed operations.

---
 rtl/alu_arbiter_2req_if.sv | 24 ++
 rtl/alu_arbiter_2req.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter_2req.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_2req_if.sv
// Request/response channel pair for one requester of the shared ALU.
// master = requester side, slave = arbiter side.
interface alu_arbiter_2req_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] out;
  logic        zero;
  logic        err;

  modport master (
    output req_valid, a, b, sel, rsp_ready,
    input  req_ready, rsp_valid, out, zero, err
  );

  modport slave (
    input  req_valid, a, b, sel, rsp_ready,
    output req_ready, rsp_valid, out, zero, err
  );
endinterface

// File: rtl/alu_arbiter_2req.sv
// Two-requester round-robin front end for a single shared 32-bit ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC -> RESP.

// Combinational 32-bit ALU; illegal select codes yield out=0, zero=0, err=1.
module alu_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] out,
  output logic        zero,
  output logic        err
);
  // Operation decode; zero is suppressed for illegal codes
  always_comb begin
    out = '0;
    err = 1'b0;
    case (sel)
      3'b000:  out = a & b;
      3'b001:  out = a | b;
      3'b100:  out = a + b;
      3'b101:  out = a - b;
      3'b110:  out = a ^ b;
      default: err = 1'b1;
    endcase
    zero = !err && (out == '0);
  end
endmodule

module alu_arbiter_2req #(
  parameter int FIRST_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_2req_if.slave port0,
  alu_arbiter_2req_if.slave port1,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam logic PRIO_RST = FIRST_PRIO[0];

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   prio;
  logic   owner;

  // Requester channels gathered into per-requester arrays
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_sel;

  // Registered response state per requester
  logic [1:0]       rsp_valid;
  logic [1:0][31:0] rsp_out;
  logic [1:0]       rsp_zero;
  logic [1:0]       rsp_err;

  // Latched operands feeding the ALU during EXEC
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sel;

  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_err;

  logic grant_vld;
  logic grant_id;

  assign req_valid = {port1.req_valid, port0.req_valid};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};
  assign req_a     = {port1.a,   port0.a};
  assign req_b     = {port1.b,   port0.b};
  assign req_sel   = {port1.sel, port0.sel};

  assign port0.req_ready = req_ready[0];
  assign port1.req_ready = req_ready[1];
  assign port0.rsp_valid = rsp_valid[0];
  assign port1.rsp_valid = rsp_valid[1];
  assign port0.out       = rsp_out[0];
  assign port1.out       = rsp_out[1];
  assign port0.zero      = rsp_zero[0];
  assign port1.zero      = rsp_zero[1];
  assign port0.err       = rsp_err[0];
  assign port1.err       = rsp_err[1];

  alu_32bit u_alu (
    .a    (op_a),
    .b    (op_b),
    .sel  (op_sel),
    .out  (alu_out),
    .zero (alu_zero),
    .err  (alu_err)
  );

  // Round-robin grant: priority holder wins, otherwise the lone valid requester
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = prio;
    if (state == IDLE) begin
      if (req_valid[prio]) begin
        grant_vld = 1'b1;
        grant_id  = prio;
      end else if (req_valid[~prio]) begin
        grant_vld = 1'b1;
        grant_id  = ~prio;
      end
    end
    req_ready = grant_vld ? (2'b01 << grant_id) : 2'b00;
  end

  // Control FSM with registered response, busy and counter outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= PRIO_RST;
      owner     <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      rsp_valid <= '0;
      rsp_out   <= '0;
      rsp_zero  <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_a   <= req_a[grant_id];
            op_b   <= req_b[grant_id];
            op_sel <= req_sel[grant_id];
            owner  <= grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_out[owner]   <= alu_out;
          rsp_zero[owner]  <= alu_zero;
          rsp_err[owner]   <= alu_err;
          rsp_valid[owner] <= 1'b1;
          state            <= RESP;
        end
        RESP: begin
          // Result held stable until the owner consumes it
          if (rsp_ready[owner]) begin
            rsp_valid[owner] <= 1'b0;
            op_count         <= op_count + 1'b1;
            prio             <= ~owner;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Grant is one-hot by construction
  a_one_ready: assert property (@(posedge clk) disable iff (reset) !(&req_ready));

endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Directed bench for alu_arbiter_2req: vector table of single ops plus
// contention, back-pressure, counter wrap and mid-operation reset sequences.
module tb_alu_arbiter_2req;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter_2req_if p0 ();
  alu_arbiter_2req_if p1 ();

  alu_arbiter_2req #(.FIRST_PRIO(0), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .port0    (p0),
    .port1    (p1),
    .busy     (busy),
    .op_count (op_count)
  );

  // Drive side
  logic        v  [2];
  logic [31:0] ia [2];
  logic [31:0] ib [2];
  logic [2:0]  is [2];
  logic        rr [2];

  assign p0.req_valid = v[0];
  assign p1.req_valid = v[1];
  assign p0.a = ia[0];
  assign p1.a = ia[1];
  assign p0.b = ib[0];
  assign p1.b = ib[1];
  assign p0.sel = is[0];
  assign p1.sel = is[1];
  assign p0.rsp_ready = rr[0];
  assign p1.rsp_ready = rr[1];

  // Observe side
  logic        rdy [2];
  logic        rv  [2];
  logic [31:0] ro  [2];
  logic        rz  [2];
  logic        re  [2];

  assign rdy[0] = p0.req_ready;
  assign rdy[1] = p1.req_ready;
  assign rv[0]  = p0.rsp_valid;
  assign rv[1]  = p1.rsp_valid;
  assign ro[0]  = p0.out;
  assign ro[1]  = p1.out;
  assign rz[0]  = p0.zero;
  assign rz[1]  = p1.zero;
  assign re[0]  = p0.err;
  assign re[1]  = p1.err;

  int checks = 0;
  int fails  = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; ia[i] = '0; ib[i] = '0; is[i] = '0; rr[i] = 1'b0;
    end
  endtask

  // Reset for two cycles, checking reset values while held
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp0_valid", 32'(rv[0]), 0);
    chk("rst_rsp1_valid", 32'(rv[1]), 0);
    chk("rst_rsp0_out", ro[0], 0);
    chk("rst_rsp1_err", 32'(re[1]), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  // Single uncontended op on requester p with immediate response consumption.
  // Called at a negedge while the DUT is IDLE; returns at a negedge in IDLE.
  task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic [31:0] eo,
                       input logic ez, input logic ee);
    v[p] = 1'b1; ia[p] = a; ib[p] = b; is[p] = sel; rr[p] = 1'b1;
    #1;
    chk("req_ready", 32'(rdy[p]), 1);
    chk("other_ready", 32'(rdy[1-p]), 0);
    @(negedge clk);
    v[p] = 1'b0;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_rsp_valid", 32'(rv[p]), 0);
    @(negedge clk);
    chk("rsp_valid", 32'(rv[p]), 1);
    chk("other_rsp_valid", 32'(rv[1-p]), 0);
    chk("rsp_out", ro[p], eo);
    chk("rsp_zero", 32'(rz[p]), 32'(ez));
    chk("rsp_err", 32'(re[p]), 32'(ee));
    @(negedge clk);
    exp_cnt++;
    chk("done_rsp_valid", 32'(rv[p]), 0);
    chk("done_busy", 32'(busy), 0);
    chk("op_count", 32'(op_count), 32'(exp_cnt % (1 << CW)));
    rr[p] = 1'b0;
  endtask

  typedef struct {
    int          p;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] out;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  int   grants [$];
  int   nrsp;

  initial begin
    tbl[0]  = '{0, 32'd2,          32'd6,          3'b100, 32'd8,          1'b0, 1'b0};
    tbl[1]  = '{1, 32'd2,          32'd2,          3'b101, 32'd0,          1'b1, 1'b0};
    tbl[2]  = '{1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  3'b100, 32'hFFFF_FFFE,  1'b0, 1'b0};
    tbl[3]  = '{0, 32'd0,          32'd1,          3'b101, 32'hFFFF_FFFF,  1'b0, 1'b0};
    tbl[4]  = '{0, 32'h0000_F0F0,  32'h0000_0FF0,  3'b000, 32'h0000_00F0,  1'b0, 1'b0};
    tbl[5]  = '{1, 32'hF000_0000,  32'h0000_000F,  3'b001, 32'hF000_000F,  1'b0, 1'b0};
    tbl[6]  = '{0, 32'h0000_1234,  32'h0000_1234,  3'b110, 32'd0,          1'b1, 1'b0};
    tbl[7]  = '{1, 32'd5,          32'd8,          3'b011, 32'd0,          1'b0, 1'b1};
    tbl[8]  = '{0, 32'd5,          32'd8,          3'b010, 32'd0,          1'b0, 1'b1};
    tbl[9]  = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'b111, 32'd0,          1'b0, 1'b1};
    tbl[10] = '{0, 32'd0,          32'd0,          3'b000, 32'd0,          1'b1, 1'b0};

    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Vector table
    for (int i = 0; i < 11; i++)
      do_op(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].out, tbl[i].zero, tbl[i].err);

    // Five more ops take the 4-bit counter from 11 through 15 to 0
    for (int i = 0; i < 5; i++)
      do_op(i % 2, 32'(i), 32'd1, 3'b100, 32'(i + 1), 1'b0, 1'b0);

    // Contention from reset: both requesters valid for 12 cycles
    do_reset();
    v[0] = 1'b1; ia[0] = 32'hAA; ib[0] = 32'hFFFF; is[0] = 3'b000; rr[0] = 1'b1;
    v[1] = 1'b1; ia[1] = 32'hAA; ib[1] = 32'hFFFF; is[1] = 3'b110; rr[1] = 1'b1;
    nrsp = 0;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk("never_both_ready", 32'(rdy[0] & rdy[1]), 0);
      if (rdy[0]) grants.push_back(0);
      if (rdy[1]) grants.push_back(1);
      if (rv[0]) begin nrsp++; chk("cont_rsp0_out", ro[0], 32'hAA); end
      if (rv[1]) begin nrsp++; chk("cont_rsp1_out", ro[1], 32'hFF55); end
      @(negedge clk);
      #1;
    end
    chk("cont_grant_count", 32'(grants.size()), 4);
    for (int g = 0; g < grants.size() && g < 4; g++)
      chk("cont_grant_order", 32'(grants[g]), 32'(g % 2));
    chk("cont_rsp_count", 32'(nrsp), 4);
    chk("cont_op_count", 32'(op_count), 4);
    v[0] = 1'b0; v[1] = 1'b0;
    exp_cnt = 4;
    @(negedge clk);

    // Back-pressure: requester 0 holds its result, requester 1 waits
    v[0] = 1'b1; ia[0] = 32'd10; ib[0] = 32'd20; is[0] = 3'b100; rr[0] = 1'b0;
    v[1] = 1'b1; ia[1] = 32'd3;  ib[1] = 32'd4;  is[1] = 3'b001; rr[1] = 1'b1;
    #1;
    chk("bp_ready0", 32'(rdy[0]), 1);
    chk("bp_ready1", 32'(rdy[1]), 0);
    @(negedge clk);
    v[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp0_valid", 32'(rv[0]), 1);
      chk("bp_rsp0_out", ro[0], 32'd30);
      chk("bp_req1_ready", 32'(rdy[1]), 0);
      @(negedge clk);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    #1;
    exp_cnt++;
    chk("bp_req1_granted", 32'(rdy[1]), 1);
    chk("bp_rsp0_dropped", 32'(rv[0]), 0);
    chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
    @(negedge clk);
    v[1] = 1'b0;
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rv[1]), 1);
    chk("bp_rsp1_out", ro[1], 32'd7);
    @(negedge clk);
    exp_cnt++;
    chk("bp_op_count2", 32'(op_count), 32'(exp_cnt));
    rr[0] = 1'b0; rr[1] = 1'b0;

    // Reset during EXEC aborts the op with no response
    v[0] = 1'b1; ia[0] = 32'd1; ib[0] = 32'd1; is[0] = 3'b100; rr[0] = 1'b1;
    @(negedge clk);
    v[0] = 1'b0;
    chk("abort_in_exec", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp0_valid", 32'(rv[0]), 0);
    chk("abort_rsp1_valid", 32'(rv[1]), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_op_count", 32'(op_count), 0);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("abort_no_rsp", 32'(rv[0]), 0);
    do_op(0, 32'd2, 32'd6, 3'b100, 32'd8, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
